// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment readback path.
//   - Active-low segment codes (bit0 = a .. bit6 = g) for digits, minus and blank.
//   - FSM state encoding for the segment-to-binary converter.
//   - dd_adjust: per-nibble correction step of the reverse double-dabble.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    SHIFT,
    SIGN,
    DONE
  } state_e;

  // After a right shift, a BCD nibble of 8 or more carried a bit in from the digit above
  // worth 10 (not 16) half-units, so take 3 back off.
  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    return (nib >= 4'd8) ? (nib - 4'd3) : nib;
  endfunction

endpackage

// File: rtl/seven_segment_to_binary_decoder_if.sv
// Handshake bundle for seven_segment_to_binary_decoder.
//   seg_in    : sign group (top) plus NUM_DIGITS digit groups, 7 bits each, group 0 = ones
//   in_valid  : seg_in valid            in_ready  : converter can accept
//   result    : two's-complement value  err       : an illegal pattern was present
//   out_valid : result/err valid        out_ready : consumer accepts
// master = producer/consumer side, slave = converter side.
interface seven_segment_to_binary_decoder_if #(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned BIN_W      = 10
);

  logic [7*(NUM_DIGITS+1)-1:0] seg_in;
  logic                        in_valid;
  logic                        in_ready;
  logic [BIN_W:0]              result;
  logic                        err;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output seg_in,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  result,
    input  err,
    input  out_valid
  );

  modport slave (
    input  seg_in,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output result,
    output err,
    output out_valid
  );

endinterface

// File: rtl/seven_segment_to_bcd_digit.sv
// Combinational decode of one active-low seven-segment digit pattern.
//   seg_i      : 7-bit pattern, bit0 = a .. bit6 = g
//   bcd_o      : decoded value 0-9 (0 when not a digit)
//   legal_o    : pattern is one of the ten digit codes
//   is_blank_o : pattern is all segments off (legality of blanks is decided by the caller)
module seven_segment_to_bcd_digit
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       legal_o,
  output logic       is_blank_o
);

  always_comb begin
    bcd_o      = 4'd0;
    legal_o    = 1'b1;
    is_blank_o = (seg_i == SEG_BLANK);
    case (seg_i)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_to_binary_decoder.sv
// Seven-segment readback: captures a sign group plus NUM_DIGITS digit groups, checks and
// decodes them to BCD, then converts to signed binary with a reverse double-dabble
// (one shift per cycle, BIN_W cycles).
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : seg_in/in_valid/in_ready in, result/err/out_valid/out_ready out
// Optional build macro LEADING_BLANK_EN: blank (1111111) digit groups are accepted as 0
// when every group above them is also blank; the ones group must never be blank.
// Without it any blank digit group is illegal.
// Legal inputs reach DONE BIN_W+2 edges after acceptance; illegal inputs reach it after 2
// edges. While DONE waits for out_ready, result/err/out_valid are held and in_ready is 0.
module seven_segment_to_binary_decoder
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned BIN_W      = 10
) (
  input logic                             clock,
  input logic                             reset,
  seven_segment_to_binary_decoder_if.slave bus
);

  localparam int unsigned SEG_W = 7 * (NUM_DIGITS + 1);
  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  state_e             state_q, state_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               err_pending_q, err_pending_d;
  logic [BIN_W:0]     result_q, result_d;
  logic               err_q, err_d;

  // Digit decode of the captured pattern
  logic [NUM_DIGITS-1:0][3:0] dig_bcd;
  logic [NUM_DIGITS-1:0]      dig_legal;
  logic [NUM_DIGITS-1:0]      dig_blank;
  logic [NUM_DIGITS-1:0]      blank_ok;
  logic [NUM_DIGITS-1:0]      dig_ok;
  logic [6:0]                 sign_seg;
  logic                       sign_neg;
  logic                       sign_legal;
  logic                       all_legal;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    seven_segment_to_bcd_digit u_digit (
      .seg_i      (seg_q[7*k +: 7]),
      .bcd_o      (dig_bcd[k]),
      .legal_o    (dig_legal[k]),
      .is_blank_o (dig_blank[k])
    );
  end

`ifdef LEADING_BLANK_EN
  // A blank is a leading blank only if every group above it is blank as well.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_blank
    if (k == 0) begin : g_ones
      assign blank_ok[k] = 1'b0;
    end else if (k == NUM_DIGITS - 1) begin : g_top
      assign blank_ok[k] = 1'b1;
    end else begin : g_mid
      assign blank_ok[k] = &dig_blank[NUM_DIGITS-1:k+1];
    end
  end
`else
  assign blank_ok = '0;
`endif

  assign dig_ok     = dig_legal | (dig_blank & blank_ok);
  assign sign_seg   = seg_q[SEG_W-1 -: 7];
  assign sign_neg   = (sign_seg == SEG_MINUS);
  assign sign_legal = sign_neg | (sign_seg == SEG_BLANK);
  assign all_legal  = sign_legal & (&dig_ok);

  // One reverse double-dabble step: shift {bcd,bin} right, then correct every nibble.
  logic [SR_W-1:0] sr_shr;
  logic [SR_W-1:0] sr_shift;

  assign sr_shr = sr_q >> 1;
  assign sr_shift[BIN_W-1:0] = sr_shr[BIN_W-1:0];
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
    assign sr_shift[BIN_W + 4*i +: 4] = dd_adjust(sr_shr[BIN_W + 4*i +: 4]);
  end

  logic [BIN_W:0] mag_ext;
  assign mag_ext = {1'b0, sr_q[BIN_W-1:0]};

  always_comb begin
    state_d       = state_q;
    seg_d         = seg_q;
    sr_d          = sr_q;
    cnt_d         = cnt_q;
    neg_d         = neg_q;
    err_pending_d = err_pending_q;
    result_d      = result_q;
    err_d         = err_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          seg_d   = bus.seg_in;
          state_d = DECODE;
        end
      end

      DECODE: begin
        neg_d         = sign_neg;
        err_pending_d = ~all_legal;
        sr_d          = {dig_bcd, {BIN_W{1'b0}}};
        cnt_d         = '0;
        // Illegal input finalises through SIGN so result/err are written in one place.
        state_d       = all_legal ? SHIFT : SIGN;
      end

      SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          cnt_d   = '0;
          state_d = SIGN;
        end
      end

      SIGN: begin
        if (err_pending_q) begin
          result_d = '0;
          err_d    = 1'b1;
        end else begin
          // Minus zero negates to zero, so no special case is needed.
          result_d = neg_q ? -mag_ext : mag_ext;
          err_d    = 1'b0;
        end
        state_d = DONE;
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      seg_q         <= '0;
      sr_q          <= '0;
      cnt_q         <= '0;
      neg_q         <= 1'b0;
      err_pending_q <= 1'b0;
      result_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      seg_q         <= seg_d;
      sr_q          <= sr_d;
      cnt_q         <= cnt_d;
      neg_q         <= neg_d;
      err_pending_q <= err_pending_d;
      result_q      <= result_d;
      err_q         <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_seven_segment_to_binary_decoder.sv
module tb_seven_segment_to_binary_decoder;

  localparam int unsigned ND = 3;
  localparam int unsigned BW = 10;
  localparam int BLANK = 10;
  localparam int BAD   = 11;

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;

  seven_segment_to_binary_decoder_if #(.NUM_DIGITS(ND), .BIN_W(BW)) bus ();

  seven_segment_to_binary_decoder #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] dseg(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      BLANK:   return 7'b1111111;
      default: return 7'b1010101;
    endcase
  endfunction

  function automatic logic [27:0] enc(input bit neg, input int d2, input int d1, input int d0);
    return {(neg ? 7'b0111111 : 7'b1111111), dseg(d2), dseg(d1), dseg(d0)};
  endfunction

  // Send one input, wait (bounded) for out_valid, sample, and complete the out handshake.
  task automatic run_conv(input logic [27:0] seg, output logic [10:0] res, output logic e,
                          output int lat);
    int guard;
    bus.seg_in   = seg;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    res = bus.result;
    e   = bus.err;
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.seg_in    = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.err !== 1'b0 ||
        bus.result !== 11'h000) begin
      tests_failed++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b err=%b result=%h, want 1 0 0 000",
               bus.in_ready, bus.out_valid, bus.err, bus.result);
    end
  endtask

  task automatic test_convert();
    logic [27:0] seg [4];
    logic [10:0] want [4];
    logic [10:0] res;
    logic        e;
    int          lat;
    seg[0] = enc(0, 1, 2, 3); want[0] = 11'h07B;
    seg[1] = enc(1, 9, 9, 9); want[1] = 11'h419;
    seg[2] = enc(0, 0, 0, 0); want[2] = 11'h000;
    seg[3] = enc(0, 5, 1, 2); want[3] = 11'h200;
    for (int i = 0; i < 4; i++) begin
      run_conv(seg[i], res, e, lat);
      tests_run++;
      if (res !== want[i] || e !== 1'b0 || lat != 12) begin
        tests_failed++;
        $display("FAIL convert_%0d: result=%h err=%b latency=%0d, want %h 0 12",
                 i, res, e, lat, want[i]);
      end
    end
  endtask

  task automatic test_minus_zero_and_illegal();
    logic [10:0] res;
    logic        e;
    int          lat;
    run_conv(enc(1, 0, 0, 0), res, e, lat);
    tests_run++;
    if (res !== 11'h000 || e !== 1'b0 || lat != 12) begin
      tests_failed++;
      $display("FAIL minus_zero: result=%h err=%b latency=%0d, want 000 0 12", res, e, lat);
    end
    run_conv(enc(0, 1, BAD, 3), res, e, lat);
    tests_run++;
    if (res !== 11'h000 || e !== 1'b1 || lat != 2) begin
      tests_failed++;
      $display("FAIL illegal_tens: result=%h err=%b latency=%0d, want 000 1 2", res, e, lat);
    end
    run_conv({7'b1111001, dseg(1), dseg(2), dseg(3)}, res, e, lat);
    tests_run++;
    if (res !== 11'h000 || e !== 1'b1 || lat != 2) begin
      tests_failed++;
      $display("FAIL illegal_sign: result=%h err=%b latency=%0d, want 000 1 2", res, e, lat);
    end
    // A good conversion after an error must clear err.
    run_conv(enc(1, 0, 0, 7), res, e, lat);
    tests_run++;
    if (res !== 11'h7F9 || e !== 1'b0 || lat != 12) begin
      tests_failed++;
      $display("FAIL after_error: result=%h err=%b latency=%0d, want 7f9 0 12", res, e, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [27:0] items [3];
    logic [10:0] want [3];
    logic [10:0] got_res [3];
    logic        got_err [3];
    int          lat;
    int          idx;
    int          got;
    logic        acc;
    items[0] = enc(0, 3, 0, 0); want[0] = 11'h12C;
    items[1] = enc(1, 0, 4, 2); want[1] = 11'h7D6;
    items[2] = enc(0, 0, 8, 1); want[2] = 11'h051;

    bus.seg_in   = enc(0, 2, 4, 6);
    bus.in_valid = 1'b1;
    @(posedge clock); #1;
    // Keep the next item presented throughout; it must not be taken before IDLE.
    bus.seg_in = items[0];
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    tests_run++;
    if (lat != 12) begin
      tests_failed++;
      $display("FAIL bp_latency: latency=%0d, want 12", lat);
    end
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (bus.result !== 11'h0F6 || bus.err !== 1'b0 || bus.in_ready !== 1'b0 ||
          bus.out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: result=%h err=%b in_ready=%b out_valid=%b, want 0f6 0 0 1",
                 c, bus.result, bus.err, bus.in_ready, bus.out_valid);
      end
      @(posedge clock); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", bus.in_ready,
               bus.out_valid);
    end

    // Back-to-back stream with the consumer always ready.
    idx = 0;
    got = 0;
    for (int c = 0; c < 80; c++) begin
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        if (got < 3) begin
          got_res[got] = bus.result;
          got_err[got] = bus.err;
        end
        got++;
      end
      @(posedge clock); #1;
      if (acc) begin
        idx++;
        if (idx < 3) bus.seg_in = items[idx];
        else bus.in_valid = 1'b0;
      end
    end
    bus.out_ready = 1'b0;
    tests_run++;
    if (got != 3) begin
      tests_failed++;
      $display("FAIL b2b_count: handshakes=%0d, want 3", got);
    end
    for (int i = 0; i < 3; i++) begin
      if (i < got) begin
        tests_run++;
        if (got_res[i] !== want[i] || got_err[i] !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_result_%0d: result=%h err=%b, want %h 0", i, got_res[i],
                   got_err[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] res;
    logic        e;
    int          lat;
    int          stray;
    bus.seg_in   = enc(0, 7, 7, 7);
    bus.in_valid = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    // Edge 1 enters SHIFT with counter 0; after edge 5 the counter is 4.
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 11'h000 ||
        bus.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b result=%h err=%b, want 1 0 000 0",
               bus.in_ready, bus.out_valid, bus.result, bus.err);
    end
    stray = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.out_valid !== 1'b0) stray++;
      @(posedge clock); #1;
    end
    tests_run++;
    if (stray != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_discard: out_valid cycles=%0d, want 0", stray);
    end
    run_conv(enc(0, 4, 5, 6), res, e, lat);
    tests_run++;
    if (res !== 11'h1C8 || e !== 1'b0 || lat != 12) begin
      tests_failed++;
      $display("FAIL after_reset: result=%h err=%b latency=%0d, want 1c8 0 12", res, e, lat);
    end
  endtask

  task automatic test_blank();
    logic [10:0] res;
    logic        e;
    int          lat;
    logic [10:0] want_res;
    logic        want_err;
    int          want_lat;
`ifdef LEADING_BLANK_EN
    want_res = 11'h007; want_err = 1'b0; want_lat = 12;
`else
    want_res = 11'h000; want_err = 1'b1; want_lat = 2;
`endif
    run_conv(enc(0, BLANK, BLANK, 7), res, e, lat);
    tests_run++;
    if (res !== want_res || e !== want_err || lat != want_lat) begin
      tests_failed++;
      $display("FAIL leading_blank: result=%h err=%b latency=%0d, want %h %b %0d",
               res, e, lat, want_res, want_err, want_lat);
    end
    run_conv(enc(0, 1, BLANK, 7), res, e, lat);
    tests_run++;
    if (res !== 11'h000 || e !== 1'b1 || lat != 2) begin
      tests_failed++;
      $display("FAIL inner_blank: result=%h err=%b latency=%0d, want 000 1 2", res, e, lat);
    end
    run_conv(enc(0, BLANK, BLANK, BLANK), res, e, lat);
    tests_run++;
    if (res !== 11'h000 || e !== 1'b1 || lat != 2) begin
      tests_failed++;
      $display("FAIL all_blank: result=%h err=%b latency=%0d, want 000 1 2", res, e, lat);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_convert();
    test_minus_zero_and_illegal();
    test_backpressure();
    test_reset_mid();
    test_blank();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
